// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: SRAM request/ready handshake, SB lane steering, LB sign extension
module mem_stage_lsu #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_mem_cs,
    input  logic [3:0]        in_mem_we,
    input  logic              in_mem_oe,
    input  logic              in_store_byte,
    input  logic              in_load_byte,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_sdata,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_write,
    output logic              stall,
    output logic              dm_cs,
    output logic              dm_oe,
    output logic [3:0]        dm_web,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_di,
    input  logic [31:0]       dm_do,
    input  logic              dm_ready,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic [4:0]        out_rd,
    output logic              out_reg_write
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Request register; only the byte-address bits the SRAM can see are kept.
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_sdata;
    logic [4:0]        req_rd;
    logic              req_reg_write;
    logic              req_oe;
    logic              req_store;
    logic              req_byte;

    logic              accept;
    logic [7:0]        lb_byte;
    logic [31:0]       load_data;

    assign accept = (state == IDLE) && in_valid && in_mem_cs;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = BUSY;
            BUSY:    if (dm_ready) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Gated by rst_n so the pipeline is never held while the unit is in reset.
    always_comb begin
        stall = rst_n && (accept || (state == BUSY));
    end

    always_comb begin
        dm_cs   = 1'b0;
        dm_oe   = 1'b0;
        dm_web  = 4'b1111;
        dm_addr = '0;
        dm_di   = 32'd0;
        if (state == BUSY) begin
            dm_cs   = 1'b1;
            dm_oe   = req_oe;
            dm_addr = req_addr[ADDR_W+1:2];
            if (req_store) begin
                if (req_byte) begin
                    dm_web = ~(4'b0001 << req_addr[1:0]);
                    dm_di  = {4{req_sdata[7:0]}};
                end else begin
                    dm_web = 4'b0000;
                    dm_di  = req_sdata;
                end
            end
        end
    end

    always_comb begin
        lb_byte = dm_do[7:0];
        case (req_addr[1:0])
            2'd1:    lb_byte = dm_do[15:8];
            2'd2:    lb_byte = dm_do[23:16];
            2'd3:    lb_byte = dm_do[31:24];
            default: lb_byte = dm_do[7:0];
        endcase
        load_data = req_byte ? {{24{lb_byte[7]}}, lb_byte} : dm_do;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_addr      <= '0;
            req_sdata     <= 32'd0;
            req_rd        <= 5'd0;
            req_reg_write <= 1'b0;
            req_oe        <= 1'b0;
            req_store     <= 1'b0;
            req_byte      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= 32'd0;
            out_rd        <= 5'd0;
            out_reg_write <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && !in_mem_cs) begin
                        out_valid     <= 1'b1;
                        out_data      <= in_addr;
                        out_rd        <= in_rd;
                        out_reg_write <= in_reg_write;
                    end else if (accept) begin
                        req_addr      <= in_addr[ADDR_W+1:0];
                        req_sdata     <= in_sdata;
                        req_rd        <= in_rd;
                        req_reg_write <= in_reg_write;
                        req_oe        <= in_mem_oe;
                        // Any mem_we pattern other than all-zero is a load.
                        req_store     <= (in_mem_we == 4'b0000);
                        req_byte      <= (in_mem_we == 4'b0000) ? in_store_byte : in_load_byte;
                    end
                end
                BUSY: begin
                    if (dm_ready) begin
                        out_valid <= 1'b1;
                        out_rd    <= req_rd;
                        if (req_store) begin
                            out_data      <= 32'd0;
                            out_reg_write <= 1'b0;
                        end else begin
                            out_data      <= load_data;
                            out_reg_write <= req_reg_write;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
